// File: rtl/l1_vc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1_vc_mem_arbiter
// Shares one line-wide memory port between the L1 refill path and the victim
// cache writeback path. Each side owns a one-entry pending slot; a four-state
// FSM serves one slot at a time and returns the memory response to its owner.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   l1_req_*              L1 request pulse (rw, addr, wdata) into the L1 slot
//   l1_resp_valid/rdata   L1 completion pulse and held read data
//   l1_busy               L1 slot occupied
//   vc_req_*              VC request pulse into the VC slot
//   vc_resp_valid/rdata   VC completion pulse and held read data
//   vc_busy               VC slot occupied
//   mem_req_*             request to memory (valid is a one-cycle pulse)
//   mem_resp_valid/rdata  memory completion for reads and writes
//   err_flags             sticky: bit0 request dropped, bit1 response timeout
//
// FSM states
//   state   | meaning
//   S_IDLE  | no transaction; pick a pending slot and record its owner
//   S_ISSUE | mem_req_valid pulse for the owner's request
//   S_WAIT  | waiting for mem_resp_valid, watchdog counting
//   S_DONE  | owner's resp_valid pulse, then back to idle
// -----------------------------------------------------------------------------
module l1_vc_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_BYTES     = 16,
    parameter int READ_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    l1_req_valid,
    input  logic                    l1_req_rw,
    input  logic [ADDR_WIDTH-1:0]   l1_req_addr,
    input  logic [LINE_BYTES*8-1:0] l1_req_wdata,
    output logic                    l1_resp_valid,
    output logic [LINE_BYTES*8-1:0] l1_resp_rdata,
    output logic                    l1_busy,
    input  logic                    vc_req_valid,
    input  logic                    vc_req_rw,
    input  logic [ADDR_WIDTH-1:0]   vc_req_addr,
    input  logic [LINE_BYTES*8-1:0] vc_req_wdata,
    output logic                    vc_resp_valid,
    output logic [LINE_BYTES*8-1:0] vc_resp_rdata,
    output logic                    vc_busy,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [LINE_BYTES*8-1:0] mem_req_wdata,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_resp_rdata,
    output logic [1:0]              err_flags
);

    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int DATA_W      = LINE_BYTES * 8;
    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int WD_W        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_l1_busy;
    logic                  r_l1_rw;
    logic [ADDR_WIDTH-1:0] r_l1_addr;
    logic [DATA_W-1:0]     r_l1_wdata;
    logic                  r_vc_busy;
    logic                  r_vc_rw;
    logic [ADDR_WIDTH-1:0] r_vc_addr;
    logic [DATA_W-1:0]     r_vc_wdata;

    logic                  r_owner_vc;
    logic                  r_rr_vc_next;
    logic                  r_mem_rw;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W-1:0]     r_l1_rdata;
    logic [DATA_W-1:0]     r_vc_rdata;
    logic [WD_W-1:0]       r_wd_cnt;
    logic [1:0]            r_err;

    logic w_any_pend;
    logic w_line_hit;
    logic w_conflict;
    logic w_grant_vc;
    logic w_timeout;
    logic w_finish;

    assign w_any_pend = r_l1_busy | r_vc_busy;
    assign w_line_hit = ((r_l1_addr ^ r_vc_addr) & LINE_MASK) == '0;
    // A refill must not overtake a writeback to the same line.
    assign w_conflict = !r_l1_rw && r_vc_rw && w_line_hit;
    // A response in the final wait cycle still wins over the timeout.
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LAST) && !mem_resp_valid;
    assign w_finish   = (r_state == S_WAIT) && (mem_resp_valid || w_timeout);

    always_comb begin
        w_grant_vc = 1'b0;
        if (r_l1_busy && r_vc_busy) begin
            if (w_conflict)
                w_grant_vc = 1'b1;
            else if (READ_PRIORITY != 0)
                w_grant_vc = 1'b0;
            else
                w_grant_vc = r_rr_vc_next;
        end else begin
            w_grant_vc = r_vc_busy;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_pend) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mem_resp_valid || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_req_valid = 1'b0;
        l1_resp_valid = 1'b0;
        vc_resp_valid = 1'b0;
        case (r_state)
            S_ISSUE: mem_req_valid = 1'b1;
            S_DONE: begin
                l1_resp_valid = !r_owner_vc;
                vc_resp_valid = r_owner_vc;
            end
            default: ;
        endcase
    end

    // ---------------- Pending slots ----------------
    // Busy drops on the edge into S_DONE so the owner can re-request while
    // its resp_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l1_busy  <= 1'b0;
            r_l1_rw    <= 1'b0;
            r_l1_addr  <= '0;
            r_l1_wdata <= '0;
        end else if (l1_req_valid && !r_l1_busy) begin
            r_l1_busy  <= 1'b1;
            r_l1_rw    <= l1_req_rw;
            r_l1_addr  <= l1_req_addr;
            r_l1_wdata <= l1_req_wdata;
        end else if (w_finish && !r_owner_vc) begin
            r_l1_busy  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vc_busy  <= 1'b0;
            r_vc_rw    <= 1'b0;
            r_vc_addr  <= '0;
            r_vc_wdata <= '0;
        end else if (vc_req_valid && !r_vc_busy) begin
            r_vc_busy  <= 1'b1;
            r_vc_rw    <= vc_req_rw;
            r_vc_addr  <= vc_req_addr;
            r_vc_wdata <= vc_req_wdata;
        end else if (w_finish && r_owner_vc) begin
            r_vc_busy  <= 1'b0;
        end
    end

    // ---------------- Transaction datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_vc   <= 1'b0;
            r_rr_vc_next <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_l1_rdata   <= '0;
            r_vc_rdata   <= '0;
            r_wd_cnt     <= '0;
            r_err        <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_pend) begin
                        r_owner_vc  <= w_grant_vc;
                        r_mem_rw    <= w_grant_vc ? r_vc_rw : r_l1_rw;
                        r_mem_addr  <= (w_grant_vc ? r_vc_addr : r_l1_addr) & LINE_MASK;
                        r_mem_wdata <= w_grant_vc ? r_vc_wdata : r_l1_wdata;
                    end
                end
                S_ISSUE: r_wd_cnt <= '0;
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (r_owner_vc) r_vc_rdata <= mem_resp_rdata;
                        else            r_l1_rdata <= mem_resp_rdata;
                    end else if (w_timeout) begin
                        r_err[1] <= 1'b1;
                        if (r_owner_vc) r_vc_rdata <= '0;
                        else            r_l1_rdata <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_DONE: r_rr_vc_next <= !r_owner_vc;
                default: ;
            endcase
            if ((l1_req_valid && r_l1_busy) || (vc_req_valid && r_vc_busy))
                r_err[0] <= 1'b1;
        end
    end

    assign l1_busy       = r_l1_busy;
    assign vc_busy       = r_vc_busy;
    assign l1_resp_rdata = r_l1_rdata;
    assign vc_resp_rdata = r_vc_rdata;
    assign mem_req_rw    = r_mem_rw;
    assign mem_req_addr  = r_mem_addr;
    assign mem_req_wdata = r_mem_wdata;
    assign err_flags     = r_err;

endmodule
